// File: rtl/xintf_reg_bank.sv
// DSP XINTF slave register bank: synchronised nCS/nRD/nWR strobes, RW control words, RO status words.
// Define XINTF_ERR_EN to build the sticky access-error flag; otherwise err is tied low.
module xintf_reg_bank #(
    parameter int                ADDR_W      = 15,
    parameter int                DATA_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'('h3FF0),
    parameter int                NUM_RW      = 8,
    parameter int                NUM_RO      = 4,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     nCS,
    input  logic                     nRD,
    input  logic                     nWR,
    input  logic [DATA_W-1:0]        data_in,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_oe,
    output logic [NUM_RW*DATA_W-1:0] ctrl_regs,
    output logic [NUM_RW-1:0]        wr_stb,
    input  logic [NUM_RO*DATA_W-1:0] stat_in,
    output logic                     err,
    input  logic                     err_clr
);

    // state | meaning
    // IDLE  | no access in progress, data bus released
    // WRITE | nWR low, sampling address/data until the strobe rises
    // READ  | selected word latched, driving the bus until nRD or nCS rises
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    state_t state;

    localparam logic [ADDR_W-1:0] RW_END = ADDR_W'(NUM_RW);
    localparam logic [ADDR_W-1:0] RO_END = ADDR_W'(NUM_RW + NUM_RO);

    logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync;
    logic                   cs_s, rd_s, wr_s, cs_d, wr_d;
    logic [ADDR_W-1:0]      offset, hold_addr, hold_off;
    logic [DATA_W-1:0]      hold_data, rd_word;
    logic                   hit_rw, hit_ro, wr_rise, strobe_clash;

    assign cs_s         = cs_sync[SYNC_STAGES-1];
    assign rd_s         = rd_sync[SYNC_STAGES-1];
    assign wr_s         = wr_sync[SYNC_STAGES-1];
    // Unsigned wrap makes addresses below the base land far above the window.
    assign offset       = address - BASE_ADDR;
    assign hold_off     = hold_addr - BASE_ADDR;
    assign hit_rw       = offset < RW_END;
    assign hit_ro       = !hit_rw && (offset < RO_END);
    assign wr_rise      = wr_s && !wr_d;
    assign strobe_clash = !rd_s && !wr_s;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_RW; i++)
            if (offset == ADDR_W'(i)) rd_word = ctrl_regs[i*DATA_W +: DATA_W];
        for (int j = 0; j < NUM_RO; j++)
            if (offset == ADDR_W'(NUM_RW + j)) rd_word = stat_in[j*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cs_sync <= '1;
            rd_sync <= '1;
            wr_sync <= '1;
            cs_d    <= 1'b1;
            wr_d    <= 1'b1;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], nCS};
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], nRD};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], nWR};
            cs_d    <= cs_s;
            wr_d    <= wr_s;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            hold_addr <= '0;
            hold_data <= '0;
            ctrl_regs <= {NUM_RW{RESET_VAL}};
            wr_stb    <= '0;
            data_out  <= '0;
            data_oe   <= 1'b0;
        end else begin
            wr_stb <= '0;
            if (strobe_clash) begin
                state   <= IDLE;
                data_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        data_oe <= 1'b0;
                        if (!cs_s && !wr_s) begin
                            state     <= WRITE;
                            hold_addr <= address;
                            hold_data <= data_in;
                        end else if (!cs_s && !rd_s && (hit_rw || hit_ro)) begin
                            state    <= READ;
                            data_out <= rd_word;
                        end
                    end
                    WRITE: begin
                        if (wr_rise && !cs_s) begin
                            state <= IDLE;
                            for (int i = 0; i < NUM_RW; i++) begin
                                if (hold_off == ADDR_W'(i)) begin
                                    ctrl_regs[i*DATA_W +: DATA_W] <= hold_data;
                                    wr_stb[i]                     <= 1'b1;
                                end
                            end
                        end else if (cs_s) begin
                            state <= IDLE;
                        end else begin
                            hold_addr <= address;
                            hold_data <= data_in;
                        end
                    end
                    READ: begin
                        if (rd_s || cs_s) begin
                            state   <= IDLE;
                            data_oe <= 1'b0;
                        end else begin
                            data_oe <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        data_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef XINTF_ERR_EN
    logic err_evt;

    always_comb begin
        err_evt = 1'b0;
        if (strobe_clash)
            err_evt = 1'b1;
        else if (state == IDLE && !cs_s && !rd_s && !hit_rw && !hit_ro)
            err_evt = 1'b1;
        else if (state == WRITE && wr_rise && !cs_s && !(hold_off < RW_END))
            err_evt = 1'b1;
    end

    // Clear has priority so software never loses a clear to a coincident event.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            err <= 1'b0;
        else if (err_clr)
            err <= 1'b0;
        else if (err_evt)
            err <= 1'b1;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

endmodule
